// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: accepts one load/store at a time, stalls
// WAIT_CYCLES+1 cycles, then presents a held response until the core takes it.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [30:0] DEPTH_L = 31'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        ready_r, valid_r, error_r;
    logic [31:0] rdata_r;
    logic        write_r, unsigned_r;
    logic [31:0] addr_r, wdata_r;
    logic [1:0]  size_r;

    logic        accept_s, finish_s, handshake_s, commit_s;
    logic        size_err_s, range_err_s, err_s;
    logic [3:0]  mask_s;
    logic [31:0] wlanes_s, rd_word_s, rsp_data_s;
    logic [AW-1:0] idx_s;

    logic [31:0] mem_r [DEPTH_WORDS];

    // Selects the addressed byte or half and extends it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (size)
            2'b00:   load_extend = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
            2'b01:   load_extend = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            2'b10:   load_extend = word;
            default: load_extend = 32'd0;
        endcase
    endfunction

    assign idx_s     = addr_r[AW+1:2];
    assign rd_word_s = mem_r[idx_s];

    assign req_ready = ready_r;
    assign rsp_valid = valid_r;
    assign rsp_rdata = rdata_r;
    assign rsp_error = error_r;

    // Error classification of the latched request.
    always_comb begin
        case (size_r)
            2'b00:   size_err_s = 1'b0;
            2'b01:   size_err_s = addr_r[0];
            2'b10:   size_err_s = (addr_r[1:0] != 2'b00);
            default: size_err_s = 1'b1;
        endcase
        range_err_s = ({1'b0, addr_r[31:2]} >= DEPTH_L);
        err_s       = size_err_s | range_err_s;
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        case (size_r)
            2'b00: begin
                mask_s   = 4'b0001 << addr_r[1:0];
                wlanes_s = {4{wdata_r[7:0]}};
            end
            2'b01: begin
                mask_s   = 4'b0011 << {addr_r[1], 1'b0};
                wlanes_s = {2{wdata_r[15:0]}};
            end
            2'b10: begin
                mask_s   = 4'b1111;
                wlanes_s = wdata_r;
            end
            default: begin
                mask_s   = 4'b0000;
                wlanes_s = 32'd0;
            end
        endcase
        rsp_data_s = (write_r || err_s) ? 32'd0
                                        : load_extend(rd_word_s, addr_r[1:0], size_r, unsigned_r);
    end

    // Next-state logic for the IDLE/BUSY/RESP sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        accept_s    = 1'b0;
        finish_s    = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && ready_r) begin
                    state_s  = BUSY;
                    cnt_s    = WAIT_L;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_s  = RESP;
                    finish_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (valid_r && rsp_ready) begin
                    state_s     = IDLE;
                    handshake_s = 1'b1;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
        commit_s = finish_s && write_r && !err_s;
    end

    // Sequencer, latched request and registered response.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            ready_r    <= 1'b0;
            valid_r    <= 1'b0;
            rdata_r    <= 32'd0;
            error_r    <= 1'b0;
            write_r    <= 1'b0;
            unsigned_r <= 1'b0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            size_r     <= 2'b00;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s == IDLE);
            if (accept_s) begin
                write_r    <= req_write;
                unsigned_r <= req_unsigned;
                addr_r     <= req_addr;
                wdata_r    <= req_wdata;
                size_r     <= req_size;
            end
            if (finish_s) begin
                valid_r <= 1'b1;
                rdata_r <= rsp_data_s;
                error_r <= err_s;
            end else if (handshake_s) begin
                valid_r <= 1'b0;
                rdata_r <= 32'd0;
                error_r <= 1'b0;
            end
        end
    end

    // Storage write port; contents intentionally survive reset.
    always_ff @(posedge clock) begin
        if (commit_s) begin
            for (int l = 0; l < 4; l++) begin
                if (mask_s[l]) begin
                    mem_r[idx_s][8*l +: 8] <= wlanes_s[8*l +: 8];
                end
            end
        end
    end

endmodule
